// File: rtl/cpu_regs_pkg.sv
// Register-bank select map shared by the writeback arbiter and the register bank.
// Mapped selects are the sixteen general registers plus the frame and stack pointers.
package cpu_regs_pkg;

    localparam int SEL_W = 6;

    localparam logic [SEL_W-1:0] REG_G0  = 6'h00;
    localparam logic [SEL_W-1:0] REG_G1  = 6'h01;
    localparam logic [SEL_W-1:0] REG_G2  = 6'h02;
    localparam logic [SEL_W-1:0] REG_G3  = 6'h03;
    localparam logic [SEL_W-1:0] REG_G4  = 6'h04;
    localparam logic [SEL_W-1:0] REG_G5  = 6'h05;
    localparam logic [SEL_W-1:0] REG_G6  = 6'h06;
    localparam logic [SEL_W-1:0] REG_G7  = 6'h07;
    localparam logic [SEL_W-1:0] REG_G8  = 6'h08;
    localparam logic [SEL_W-1:0] REG_G9  = 6'h09;
    localparam logic [SEL_W-1:0] REG_G10 = 6'h0A;
    localparam logic [SEL_W-1:0] REG_G11 = 6'h0B;
    localparam logic [SEL_W-1:0] REG_G12 = 6'h0C;
    localparam logic [SEL_W-1:0] REG_G13 = 6'h0D;
    localparam logic [SEL_W-1:0] REG_G14 = 6'h0E;
    localparam logic [SEL_W-1:0] REG_G15 = 6'h0F;
    localparam logic [SEL_W-1:0] REG_FP  = 6'h16;
    localparam logic [SEL_W-1:0] REG_SP  = 6'h17;

    function automatic logic is_mapped_reg(input logic [SEL_W-1:0] sel);
        return (sel <= REG_G15) || (sel == REG_FP) || (sel == REG_SP);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last granted index.
// The pointer only advances when a grant is actually issued.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic                  en,
    output logic [N-1:0]          grant
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;
    int               cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        if (en) begin
            for (int off = 1; off <= N; off++) begin
                cand = int'(ptr) + off;
                if (cand >= N) cand = cand - N;
                if (!found && req[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = PTR_W'(cand);
                    found       = 1'b1;
                end
            end
        end
    end

    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PTR_W'(N - 1);
        end else if (found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Shares the register-bank write port between NREQ writeback sources through a
// round-robin grant, a select filter and a one-cycle registered output stage.
module regbank_wr_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 64,
    parameter int SEL_W  = cpu_regs_pkg::SEL_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*SEL_W-1:0]  req_sel,
    input  logic [NREQ*DATA_W-1:0] req_val,
    input  logic                   wb_stall,
    output logic [SEL_W-1:0]       regsel,
    output logic [DATA_W-1:0]      reg_val,
    output logic                   reg_we,
    output logic                   bad_sel,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic                   rd_hazard
);

    import cpu_regs_pkg::*;

    // Handshake: requester i transfers on the edge where req_valid[i] & req_ready[i];
    // it holds sel/val stable until then, and ready is never asserted during reset or stall.
    logic              xfer;
    logic [SEL_W-1:0]  sel_mux;
    logic [DATA_W-1:0] val_mux;
    logic              pend_hit;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (!wb_stall && !reset),
        .grant (req_ready)
    );

    assign xfer = |req_ready;

    always_comb begin
        sel_mux = '0;
        val_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_mux = sel_mux | req_sel[i*SEL_W +: SEL_W];
                val_mux = val_mux | req_val[i*DATA_W +: DATA_W];
            end
        end
    end

    // Unmapped selects still load regsel/reg_val so the offending write is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            regsel  <= '0;
            reg_val <= '0;
            reg_we  <= 1'b0;
            bad_sel <= 1'b0;
        end else if (xfer) begin
            regsel  <= sel_mux;
            reg_val <= val_mux;
            reg_we  <= is_mapped_reg(sel_mux);
            bad_sel <= !is_mapped_reg(sel_mux);
        end else begin
            reg_we  <= 1'b0;
            bad_sel <= 1'b0;
        end
    end

    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend_hit = pend_hit | (req_valid[i] && (req_sel[i*SEL_W +: SEL_W] == rd_sel));
        end
    end

    assign rd_hazard = (reg_we && (regsel == rd_sel)) || pend_hit;

endmodule
